// File: rtl/if_types_pkg.sv
// Shared CPU-interface types, including the key/value controller additions.
package if_types_pkg;

    // Request operation encoding driven by the interface FSM.
    typedef enum logic [2:0] {
        IF_READ   = 3'd0,
        IF_UPSERT = 3'd1,
        IF_DELETE = 3'd2
    } request_operation_e;

    typedef struct packed {
        logic [15:0] key;
        logic [63:0] value;
    } request_data_t;

    localparam int unsigned KV_NUM_ENTRIES_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_EXEC   = 2'd2,
        ST_DONE   = 2'd3
    } kv_ctrl_state_e;

    typedef struct packed {
        logic        hit;
        logic        err;
        logic [63:0] value;
    } kv_result_t;

endpackage

// File: rtl/kv_match_unit.sv
// Combinational associative lookup over the key/value table.
module kv_match_unit #(
    parameter int unsigned  NUM_ENTRIES = 8,
    parameter int unsigned  KEY_WIDTH   = 16,
    localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0]                valid_i,
    input  logic [NUM_ENTRIES-1:0][KEY_WIDTH-1:0] keys_i,
    input  logic [KEY_WIDTH-1:0]                  key_i,
    output logic [NUM_ENTRIES-1:0]                match_o,
    output logic                                  hit_o,
    output logic [IDX_W-1:0]                      match_idx_o,
    output logic                                  any_free_o,
    output logic [IDX_W-1:0]                      free_idx_o
);

    logic [NUM_ENTRIES-1:0] w_match;
    logic [IDX_W-1:0]       w_match_idx;
    logic [IDX_W-1:0]       w_free_idx;

    // Match vector, encoded match index (one-hot by invariant) and lowest free slot.
    always_comb begin
        w_match     = '0;
        w_match_idx = '0;
        w_free_idx  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_match[i] = valid_i[i] && (keys_i[i] == key_i);
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_match[i]) begin
                w_match_idx = w_match_idx | IDX_W'(i);
            end
        end
        // Scan downwards so the lowest free index wins.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign match_o     = w_match;
    assign hit_o       = |w_match;
    assign match_idx_o = w_match_idx;
    assign any_free_o  = ~&valid_i;
    assign free_idx_o  = w_free_idx;

endmodule

// File: rtl/kv_store_ctrl.sv
// Key/value store responder: FSM, table storage, entry counter and optional
// round-robin eviction when the table is full (macro KV_STORE_EVICT_EN).
module kv_store_ctrl
    import if_types_pkg::*;
#(
    parameter int unsigned  NUM_ENTRIES = KV_NUM_ENTRIES_DEFAULT,
    parameter int unsigned  KEY_WIDTH   = 16,
    parameter int unsigned  VALUE_WIDTH = 64,
    localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES),
    localparam int unsigned CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [2:0]             operation_i,
    input  logic [KEY_WIDTH-1:0]   key_i,
    input  logic [VALUE_WIDTH-1:0] value_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   hit_o,
    output logic                   err_o,
    output logic [VALUE_WIDTH-1:0] value_o,
    output logic [CNT_W-1:0]       count_o
);

    kv_ctrl_state_e r_state, w_state_next;

    request_operation_e r_op;
    logic [KEY_WIDTH-1:0]   r_key;
    logic [VALUE_WIDTH-1:0] r_wdata;

    logic [NUM_ENTRIES-1:0]                  r_valid;
    logic [NUM_ENTRIES-1:0][KEY_WIDTH-1:0]   r_keys;
    logic [NUM_ENTRIES-1:0][VALUE_WIDTH-1:0] r_vals;

    logic [NUM_ENTRIES-1:0] w_match, r_match;
    logic                   w_hit, r_hit_lk;
    logic [IDX_W-1:0]       w_match_idx, r_match_idx;
    logic                   w_any_free, r_any_free;
    logic [IDX_W-1:0]       w_free_idx, r_free_idx;

    logic                   r_busy, r_done, r_hit, r_err;
    logic [VALUE_WIDTH-1:0] r_value;
    logic [CNT_W-1:0]       r_count;

    logic [NUM_ENTRIES-1:0] w_valid_next;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_wr_en;
    logic [IDX_W-1:0]       w_wr_idx;
    logic                   w_res_hit, w_res_err;
    logic [VALUE_WIDTH-1:0] w_res_value;

`ifdef KV_STORE_EVICT_EN
    logic [IDX_W-1:0] r_evict_ptr;
    logic             w_evict;
`endif

    kv_match_unit #(
        .NUM_ENTRIES(NUM_ENTRIES),
        .KEY_WIDTH  (KEY_WIDTH)
    ) u_match (
        .valid_i    (r_valid),
        .keys_i     (r_keys),
        .key_i      (r_key),
        .match_o    (w_match),
        .hit_o      (w_hit),
        .match_idx_o(w_match_idx),
        .any_free_o (w_any_free),
        .free_idx_o (w_free_idx)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: fixed walk through lookup, execute and done.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (start_i) w_state_next = ST_LOOKUP;
            ST_LOOKUP: w_state_next = ST_EXEC;
            ST_EXEC:   w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Execute-stage decision: table update, counter update and results.
    always_comb begin
        w_valid_next = r_valid;
        w_count_next = r_count;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_match_idx;
        w_res_hit    = 1'b0;
        w_res_err    = 1'b0;
        w_res_value  = '0;
`ifdef KV_STORE_EVICT_EN
        w_evict      = 1'b0;
`endif
        case (r_op)
            IF_READ: begin
                w_res_hit = r_hit_lk;
                if (r_hit_lk) w_res_value = r_vals[r_match_idx];
            end
            IF_UPSERT: begin
                if (r_hit_lk) begin
                    w_wr_en   = 1'b1;
                    w_res_hit = 1'b1;
                end else if (r_any_free) begin
                    w_wr_en                  = 1'b1;
                    w_wr_idx                 = r_free_idx;
                    w_valid_next[r_free_idx] = 1'b1;
                    w_count_next             = r_count + CNT_W'(1);
                end else begin
`ifdef KV_STORE_EVICT_EN
                    // Slot stays valid; the victim key was a miss so no duplicate arises.
                    w_wr_en  = 1'b1;
                    w_wr_idx = r_evict_ptr;
                    w_evict  = 1'b1;
`else
                    w_res_err = 1'b1;
`endif
                end
            end
            IF_DELETE: begin
                if (r_hit_lk) begin
                    w_valid_next = r_valid & ~r_match;
                    w_count_next = r_count - CNT_W'(1);
                    w_res_hit    = 1'b1;
                end
            end
            default: w_res_err = 1'b1;
        endcase
    end

    // Request latch, lookup registers, table valid bits and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= IF_READ;
            r_key       <= '0;
            r_wdata     <= '0;
            r_match     <= '0;
            r_hit_lk    <= 1'b0;
            r_match_idx <= '0;
            r_any_free  <= 1'b0;
            r_free_idx  <= '0;
            r_valid     <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hit       <= 1'b0;
            r_err       <= 1'b0;
            r_value     <= '0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= (w_state_next == ST_DONE);
            if (r_state == ST_IDLE && start_i) begin
                r_op    <= request_operation_e'(operation_i);
                r_key   <= key_i;
                r_wdata <= value_i;
            end
            if (r_state == ST_LOOKUP) begin
                r_match     <= w_match;
                r_hit_lk    <= w_hit;
                r_match_idx <= w_match_idx;
                r_any_free  <= w_any_free;
                r_free_idx  <= w_free_idx;
            end
            if (r_state == ST_EXEC) begin
                r_valid <= w_valid_next;
                r_count <= w_count_next;
                r_hit   <= w_res_hit;
                r_err   <= w_res_err;
                r_value <= w_res_value;
            end
        end
    end

    // Key and value storage carries no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (r_state == ST_EXEC && w_wr_en) begin
            r_keys[w_wr_idx] <= r_key;
            r_vals[w_wr_idx] <= r_wdata;
        end
    end

`ifdef KV_STORE_EVICT_EN
    // Round-robin victim pointer, advanced only when an eviction happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evict_ptr <= '0;
        end else if (r_state == ST_EXEC && w_evict) begin
            r_evict_ptr <= r_evict_ptr + IDX_W'(1);
        end
    end
`endif

    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign hit_o   = r_hit;
    assign err_o   = r_err;
    assign value_o = r_value;
    assign count_o = r_count;

endmodule

// File: doc/kv_store_ctrl.md
# kv_store_ctrl

Responder side of the CPU interface request handshake: accepts a one-cycle `start_i` pulse carrying an operation, key and value. It executes the operation against an on-chip fully associative key/value table and answers with a one-cycle `done_o` pulse plus hit/error/read-data results. It sits directly below the AXI-facing interface FSM, which drives its inputs and waits in its WAIT state for `done_o`.

## Interface
- `NUM_ENTRIES`, default 8: table depth; power of two, at least 2.
- `KEY_WIDTH`, default 16: key width; matches `request_data_t.key`.
- `VALUE_WIDTH`, default 64: value width; matches `request_data_t.value`.
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `start_i` in, 1: request strobe; sampled only in `ST_IDLE`.
- `operation_i` in, 3: `request_operation_e` encoding: `IF_READ`=0, `IF_UPSERT`=1, `IF_DELETE`=2.
- `key_i` in, `KEY_WIDTH`: request key.
- `value_i` in, `VALUE_WIDTH`: upsert data.
- `busy_o` out, 1: request in flight.
- `done_o` out, 1: one-cycle completion pulse.
- `hit_o` out, 1: key was present at lookup.
- `err_o` out, 1: request failed; see Operation.
- `value_o` out, `VALUE_WIDTH`: read data.
- `count_o` out, `$clog2(NUM_ENTRIES+1)`: number of valid entries.

## Operation
- Table storage per entry is `valid`, `key` and `value`. Invariant: at most one valid entry per key.
- FSM states are `ST_IDLE`, `ST_LOOKUP`, `ST_EXEC` and `ST_DONE`.
- `ST_IDLE`:
  - `start_i`=1 latches operation, key and value, then goes to `ST_LOOKUP`.
  - A `start_i` pulse in any other state is ignored. Nothing is queued.
- `ST_LOOKUP`: the match vector, hit flag, match index and lowest free index are registered, then the FSM goes to `ST_EXEC`.
- `ST_EXEC`: the table is updated and the results are registered, then the FSM goes to `ST_DONE`.
  - `IF_READ`, hit: `value_o` = stored value, `hit_o`=1.
  - `IF_READ`, miss: `value_o`=0, `hit_o`=0. Not an error.
  - `IF_UPSERT`, hit: overwrite the value; `count_o` unchanged.
  - `IF_UPSERT`, miss with a free slot: write to the lowest-index free slot; `count_o`+1.
  - `IF_UPSERT`, miss with the table full: see Configuration.
  - `IF_DELETE`, hit: clear `valid`; `count_o`-1.
  - `IF_DELETE`, miss: no change, `hit_o`=0, `err_o`=0.
  - Operation codes 3–7: no table change, `err_o`=1, `hit_o`=0, `value_o`=0.
  - `value_o` is 0 for any operation other than `IF_READ`.
- `ST_DONE`: `done_o`=1, then the FSM returns to `ST_IDLE`.
- `hit_o`, `err_o` and `value_o` hold their values until the next `ST_EXEC`.
- `count_o` never exceeds `NUM_ENTRIES` and never underflows.
- Reset values: all outputs 0, all `valid` bits 0, FSM in `ST_IDLE`, eviction pointer 0.
- Key and value storage is not reset.
- Reset asserted mid-request aborts it: no `done_o`, table cleared.

## Timing
- Fixed latency: with `start_i` high in cycle 0, `busy_o` is high in cycles 1–3 and `done_o` is high only in cycle 3.
- Cycle 4 is `ST_IDLE`. The earliest next accepted start is cycle 4, giving a 4-cycle issue interval.
- Table writes take effect at the end of cycle 2, so a request accepted in cycle 4 sees them.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro `KV_STORE_EVICT_EN` controls the upsert-miss-with-table-full case.
- Defined:
  - The entry at the round-robin eviction pointer is overwritten with the new key and value.
  - The pointer then advances by one, wrapping from `NUM_ENTRIES`-1 to 0. It advances only on evictions.
  - `hit_o`=0, `err_o`=0, `count_o` unchanged.
- Undefined:
  - No table change, `err_o`=1, `hit_o`=0.
  - No eviction pointer is present.

## Structure
- Additions to `if_types_pkg`:
  - `kv_ctrl_state_e`: a 2-bit enum of the four states.
  - `kv_result_t`: a packed struct of `hit`, `err` and `value`.
  - Parameter `KV_NUM_ENTRIES_DEFAULT`=8.
- Reuse `request_operation_e`; do not redefine it.
- Sub-module `kv_match_unit` (combinational) takes the valid vector, stored keys and lookup key. It produces the match one-hot, hit, match index, any-free flag and lowest free index.
- `kv_store_ctrl` owns the FSM, storage, counters and eviction pointer.

## Test plan
- Reset, then `IF_READ` key 0x1234 → `done_o` in cycle 3; `hit_o`=0, `err_o`=0, `value_o`=0, `count_o`=0.
- `IF_UPSERT` 0x1234 / 0xDEAD_BEEF_0000_0001, then `IF_READ` 0x1234 → `hit_o`=1, `value_o`=0xDEAD_BEEF_0000_0001, `count_o`=1.
- `IF_UPSERT` 0x1234 with a new value, then `IF_DELETE` 0x1234 → upsert: `hit_o`=1, `count_o` stays 1. Delete: `hit_o`=1, `count_o`=0. Subsequent `IF_READ`: `hit_o`=0.
- Fill keys 0..7, then `IF_UPSERT` key 8:
  - Macro defined: entry 0 is replaced, `err_o`=0, `count_o`=8, and a read of key 0 misses.
  - Macro undefined: `err_o`=1, and a read of key 0 hits.
- `operation_i`=5 → `err_o`=1, table unchanged. A `start_i` pulse in cycle 2 of a request produces no second `done_o`.
- `rst_n` low during `ST_EXEC` of an upsert → no `done_o`, `count_o`=0, and a read of that key misses.
